embedded_cpu_debug_monitor_ram: RTL

Debug monitor memory sitting directly downstream of the CPU debug-slave wrapper, in the system clock domain. It consumes the wrapper's `jdo` word and its `ocimem` action strobes to perform JTAG-initiated reads and writes of a 256×32 on-chip monitor RAM. It returns `MonDReg`, `monitor_ready` and `monitor_error` to the wrapper. The CPU reaches the same RAM through an Avalon-MM slave port, arbitrated cycle by cycle.

---
 rtl/embedded_cpu_debug_pkg.sv | 32 +++
 rtl/embedded_cpu_debug_monitor_ram_sp.sv | 46 ++++
 rtl/embedded_cpu_debug_monitor_ram.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/embedded_cpu_debug_pkg.sv
// ---------------------------------------------------------------------------
// embedded_cpu_debug_pkg
// Shared definitions for the debug monitor RAM: bit positions of the fields
// carried in the debug slave's jdo command word, the arbiter/sequencer state
// encoding, and the kind of JTAG operation held in the pending register.
// ---------------------------------------------------------------------------
package embedded_cpu_debug_pkg;

  // Command a: word address, read request and clear-error flag.
  localparam int JDO_ADDR_HI    = 25;
  localparam int JDO_ADDR_LO    = 18;
  localparam int JDO_RD_BIT     = 17;
  localparam int JDO_CLRERR_BIT = 16;

  // Command b: write data.
  localparam int JDO_WDATA_HI   = 34;
  localparam int JDO_WDATA_LO   = 3;

  typedef enum logic [2:0] {
    ST_IDLE,      // arbitration point; CPU writes also complete here
    ST_JRD,       // JTAG read: RAM output register holds the word
    ST_JRD_DONE,  // JTAG read finished, MonDReg loaded
    ST_JWR,       // JTAG write issued in the previous cycle
    ST_CRD        // CPU read data on readdata, waitrequest released
  } state_t;

  typedef enum logic {
    OP_READ,
    OP_WRITE
  } pend_op_t;

endpackage

// File: rtl/embedded_cpu_debug_monitor_ram_sp.sv
// ---------------------------------------------------------------------------
// embedded_cpu_debug_monitor_ram_sp
// Single-port synchronous RAM, 2^ADDR_W words of DATA_W bits, byte-enabled
// write and one-cycle registered read. The output register is cleared by
// reset and holds its value when no read is requested.
//   clk    system clock
//   reset  synchronous active-high reset (output register only)
//   re     read enable: q <= mem[addr] at the next edge
//   we     write enable, lanes selected by be
//   be     byte-lane enables for writes
//   addr   word address
//   wdata  write data
//   q      registered read data
// ---------------------------------------------------------------------------
module embedded_cpu_debug_monitor_ram_sp #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                re,
  input  logic                we,
  input  logic [DATA_W/8-1:0] be,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  output logic [DATA_W-1:0]   q
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // NOTE: the storage array is deliberately not reset; clearing every word
  // would turn the array into flops. Only the read register below is reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < DATA_W/8; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset)   q <= '0;
    else if (re) q <= mem[addr];
  end

endmodule

// File: rtl/embedded_cpu_debug_monitor_ram.sv
// ---------------------------------------------------------------------------
// embedded_cpu_debug_monitor_ram
// JTAG debug monitor memory. JTAG commands arrive as strobes plus the jdo word
// from the debug slave wrapper and are parked in a one-entry pending register;
// the CPU reaches the same RAM through an Avalon-MM slave. Arbitration happens
// in IDLE: a pending JTAG op wins over a new CPU request, a CPU read already
// in CRD is never preempted.
//   clk, reset                 system clock, synchronous active-high reset
//   jdo                        command word, valid on strobe cycles
//   take_action_ocimem_a       load address, optionally read
//   take_no_action_ocimem_a    increment address, then read
//   take_action_ocimem_b       write MonDReg data at address, then increment
//   MonDReg                    JTAG data register
//   monitor_ready              last JTAG command completed
//   monitor_error              sticky overrun flag
//   address, read, write,
//   writedata, byteenable      CPU Avalon-MM request
//   readdata, waitrequest      CPU Avalon-MM response
// ---------------------------------------------------------------------------
module embedded_cpu_debug_monitor_ram
  import embedded_cpu_debug_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  output logic [DATA_W-1:0] MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  input  logic [3:0]        byteenable,
  output logic [31:0]       readdata,
  output logic              waitrequest
);

  state_t            state;
  logic              pend_valid;
  pend_op_t          pend_op;
  logic [ADDR_W-1:0] mon_a_reg;

  logic              ram_re;
  logic              ram_we;
  logic [3:0]        ram_be;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_q;

  // jdo bits outside every command field.
  logic jdo_unused;
  assign jdo_unused = ^{jdo[37:JDO_WDATA_HI+1], jdo[JDO_WDATA_LO-1:0]};

  logic strobe, accept, cpu_slot, cpu_wr_go;
  assign strobe    = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
  // A strobe is taken only when nothing JTAG-side is outstanding.
  assign accept    = (state == ST_IDLE) && !pend_valid;
  // The CPU owns IDLE only when no JTAG op was pending at the start of the cycle.
  assign cpu_slot  = (state == ST_IDLE) && !pend_valid;
  assign cpu_wr_go = cpu_slot && write && !read;

  assign waitrequest = !reset && (read ? (state != ST_CRD) : (write && !cpu_wr_go));
  assign readdata    = ram_q;

  // RAM port steering. The JTAG access is issued in the IDLE cycle that
  // grants it, so the read data is registered by the time the FSM is in JRD.
  always_comb begin
    // NOTE: every output gets a default before the branches, otherwise the
    // unassigned paths would infer latches.
    ram_re    = 1'b0;
    ram_we    = 1'b0;
    ram_be    = 4'hF;
    ram_addr  = mon_a_reg;
    ram_wdata = MonDReg;
    if (!reset && state == ST_IDLE) begin
      if (pend_valid) begin
        if (pend_op == OP_READ) ram_re = 1'b1;
        else                    ram_we = 1'b1;
      end else if (read) begin
        ram_re   = 1'b1;
        ram_addr = address;
      end else if (write) begin
        ram_we    = 1'b1;
        ram_addr  = address;
        ram_be    = byteenable;
        ram_wdata = writedata;
      end
    end
  end

  embedded_cpu_debug_monitor_ram_sp #(
    .ADDR_W (ADDR_W),
    .DATA_W (32)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .re    (ram_re),
    .we    (ram_we),
    .be    (ram_be),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .q     (ram_q)
  );

  // NOTE: all state below is updated with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      pend_valid    <= 1'b0;
      pend_op       <= OP_READ;
      mon_a_reg     <= '0;
      MonDReg       <= '0;
      monitor_ready <= 1'b0;
      monitor_error <= 1'b0;
    end else begin
      // Command intake. accept implies pend_valid=0, so this never collides
      // with the IDLE branch below that retires the pending op.
      if (strobe) begin
        if (!accept) begin
          monitor_error <= 1'b1;
        end else begin
          monitor_ready <= 1'b0;
          if (take_action_ocimem_a) begin
            mon_a_reg <= jdo[JDO_ADDR_LO +: ADDR_W];
            if (jdo[JDO_CLRERR_BIT]) monitor_error <= 1'b0;
            if (jdo[JDO_RD_BIT]) begin
              pend_valid <= 1'b1;
              pend_op    <= OP_READ;
            end else begin
              monitor_ready <= 1'b1;
            end
          end else if (take_no_action_ocimem_a) begin
            mon_a_reg  <= mon_a_reg + 1'b1;
            pend_valid <= 1'b1;
            pend_op    <= OP_READ;
          end else begin
            MonDReg    <= jdo[JDO_WDATA_LO +: DATA_W];
            pend_valid <= 1'b1;
            pend_op    <= OP_WRITE;
          end
        end
      end

      case (state)
        ST_IDLE: begin
          if (pend_valid) begin
            pend_valid <= 1'b0;
            if (pend_op == OP_READ) begin
              state <= ST_JRD;
            end else begin
              // The write goes to the RAM this cycle; retire it now.
              state         <= ST_JWR;
              mon_a_reg     <= mon_a_reg + 1'b1;
              monitor_ready <= 1'b1;
            end
          end else if (read) begin
            state <= ST_CRD;
          end
        end
        ST_JRD: begin
          MonDReg       <= ram_q;
          monitor_ready <= 1'b1;
          state         <= ST_JRD_DONE;
        end
        ST_JRD_DONE, ST_JWR, ST_CRD: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
